// File: rtl/sram_controller_pkg.sv
// ----------------------------------------------------------------------------
// sram_controller_pkg
// Shared definitions for the MEM-stage SRAM responder: default widths, data
// memory base address, FSM state encodings and the latched operation type.
// ----------------------------------------------------------------------------
package sram_controller_pkg;

    // Core-side widths
    localparam int unsigned DEF_ADDRESS_LEN   = 32;
    localparam int unsigned DEF_REGISTER_LEN  = 32;

    // Board SRAM geometry and data-memory placement
    localparam int unsigned DEF_SRAM_ADDR_LEN = 18;
    localparam int unsigned DEF_SRAM_DATA_LEN = 16;
    localparam int unsigned DEF_BASE_ADDR     = 1024;
    localparam int unsigned DEF_PHASE_CYCLES  = 3;

    // FSM state encodings (2 bits)
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_LOW  = 2'd1;
    localparam logic [STATE_W-1:0] S_HIGH = 2'd2;
    localparam logic [STATE_W-1:0] S_DONE = 2'd3;

    // Operation captured when a request is accepted
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Phase counter width; a 1-cycle phase still needs a 1-bit counter
    function automatic int unsigned cnt_width(input int unsigned phases);
        return (phases > 1) ? $clog2(phases) : 1;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
// Answers 32-bit load/store requests from the MEM stage using an external
// 16-bit asynchronous SRAM. Each word is moved as two half-word accesses
// (low half, then high half), each lasting PHASE_CYCLES clocks. ready stays
// low for the whole transaction so the core can freeze its pipeline.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   wr_en      store request
//   rd_en      load request
//   address    byte address of the access
//   write_data store data
//   read_data  last completed load result
//   ready      0 while a transaction is in progress (combinational)
//   SRAM_DQ    SRAM bidirectional data bus
//   SRAM_ADDR  SRAM half-word address
//   SRAM_WE_N  SRAM write strobe, active low
//   SRAM_OE_N  SRAM output enable, active low
// ----------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned ADDRESS_LEN   = DEF_ADDRESS_LEN,
    parameter int unsigned REGISTER_LEN  = DEF_REGISTER_LEN,
    parameter int unsigned SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
    parameter int unsigned SRAM_DATA_LEN = DEF_SRAM_DATA_LEN,
    parameter int unsigned BASE_ADDR     = DEF_BASE_ADDR,
    parameter int unsigned PHASE_CYCLES  = DEF_PHASE_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N
);

    localparam int unsigned CNT_W  = cnt_width(PHASE_CYCLES);
    localparam int unsigned WORD_W = SRAM_ADDR_LEN - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    // FSM and latched request
    logic [STATE_W-1:0]       r_state,     w_state_next;
    logic [CNT_W-1:0]         r_cnt,       w_cnt_next;
    op_e                      r_op,        w_op_next;
    logic [WORD_W-1:0]        r_word,      w_word_next;
    logic [REGISTER_LEN-1:0]  r_wdata,     w_wdata_next;
    logic [REGISTER_LEN-1:0]  r_rdata,     w_rdata_next;

    // Registered SRAM pin state, aligned with the FSM state it belongs to
    logic [SRAM_ADDR_LEN-1:0] r_sram_addr, w_sram_addr_next;
    logic                     r_we_n,      w_we_n_next;
    logic                     r_oe_n,      w_oe_n_next;
    logic                     r_dq_oe,     w_dq_oe_next;
    logic [SRAM_DATA_LEN-1:0] r_dq_out,    w_dq_out_next;

    logic [ADDRESS_LEN-1:0]   w_offset;
    logic [WORD_W-1:0]        w_req_word;
    logic                     w_req;
    logic                     w_phase_end;
    logic                     w_next_in_access;
    logic                     w_next_is_high;
    logic                     w_unused_addr;

    // Address map: rebase, drop the byte offset, keep only what the SRAM decodes
    assign w_offset      = address - ADDRESS_LEN'(BASE_ADDR);
    assign w_req_word    = w_offset[2 +: WORD_W];
    assign w_unused_addr = ^{w_offset[ADDRESS_LEN-1:WORD_W+2], w_offset[1:0]};

    assign w_req       = wr_en | rd_en;
    assign w_phase_end = (r_cnt == CNT_LAST);

    // Next-state, latched request, read capture and next SRAM pin values
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_op_next        = r_op;
        w_word_next      = r_word;
        w_wdata_next     = r_wdata;
        w_rdata_next     = r_rdata;
        w_sram_addr_next = r_sram_addr;
        w_we_n_next      = 1'b1;
        w_oe_n_next      = 1'b1;
        w_dq_oe_next     = 1'b0;
        w_dq_out_next    = r_dq_out;
        w_next_in_access = 1'b0;
        w_next_is_high   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    // Write wins when both requests are raised together
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                    w_op_next    = wr_en ? OP_WRITE : OP_READ;
                    w_word_next  = w_req_word;
                    w_wdata_next = write_data;
                end
            end
            S_LOW: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (w_phase_end) begin
                    if (r_op == OP_READ) begin
                        w_rdata_next[0 +: SRAM_DATA_LEN] = SRAM_DQ;
                    end
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end
            end
            S_HIGH: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                if (w_phase_end) begin
                    if (r_op == OP_READ) begin
                        w_rdata_next[SRAM_DATA_LEN +: SRAM_DATA_LEN] = SRAM_DQ;
                    end
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Pins are computed for the state being entered so they change with it
        w_next_in_access = (w_state_next == S_LOW) || (w_state_next == S_HIGH);
        w_next_is_high   = (w_state_next == S_HIGH);

        if (w_next_in_access) begin
            w_sram_addr_next = {w_word_next, w_next_is_high};
            if (w_op_next == OP_WRITE) begin
                w_we_n_next   = 1'b0;
                w_dq_oe_next  = 1'b1;
                w_dq_out_next = w_next_is_high
                              ? w_wdata_next[SRAM_DATA_LEN +: SRAM_DATA_LEN]
                              : w_wdata_next[0 +: SRAM_DATA_LEN];
            end else begin
                w_oe_n_next = 1'b0;
            end
        end
    end

    // State and pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= OP_READ;
            r_word      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_op        <= w_op_next;
            r_word      <= w_word_next;
            r_wdata     <= w_wdata_next;
            r_rdata     <= w_rdata_next;
            r_sram_addr <= w_sram_addr_next;
            r_we_n      <= w_we_n_next;
            r_oe_n      <= w_oe_n_next;
            r_dq_oe     <= w_dq_oe_next;
            r_dq_out    <= w_dq_out_next;
        end
    end

    // rst masks the strobes and the bus immediately, so an aborted store
    // cannot land another half-word while reset is being applied
    assign SRAM_WE_N = r_we_n | rst;
    assign SRAM_OE_N = r_oe_n | rst;
    assign SRAM_DQ   = (r_dq_oe && !rst) ? r_dq_out : {SRAM_DATA_LEN{1'bz}};
    assign SRAM_ADDR = r_sram_addr;
    assign read_data = r_rdata;

    // Low in the IDLE cycle that accepts a request and throughout LOW/HIGH
    assign ready = ((r_state == S_IDLE) && !wr_en && !rd_en) || (r_state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_controller
// Directed bench for sram_controller with a behavioural asynchronous 16-bit
// SRAM. Stimulus pushes expected results into queues; a monitor process pops
// and compares them (transaction results when ready rises, pin snapshots on
// requested cycles) and prints the summary.
// ----------------------------------------------------------------------------
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Undriven bus floats to all ones so high-Z is observable
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
    end

    // Behavioural SRAM: async read, write sampled mid-cycle while WE_N is low
    logic [15:0] mem [0:63] = '{default: 16'h0000};
    logic        unused_addr_hi;
    assign unused_addr_hi = ^sram_addr[17:6];
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
    always @(negedge clk) begin
        if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          lo_idx;
        logic [15:0] lo;
        logic [15:0] hi;
        int          lat;
    } txn_t;

    typedef struct {
        string       name;
        logic        rdy;
        logic        we_n;
        logic        oe_n;
        logic [15:0] dq;
        logic [31:0] rdata;
        int          mem_idx;
        logic [15:0] mem_val;
    } snap_t;

    txn_t  q_txn  [$];
    snap_t q_snap [$];
    int    checks = 0;
    int    errors = 0;
    logic  done   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic push_txn(input string name, input logic [31:0] rdata, input int lo_idx,
                            input logic [15:0] lo, input logic [15:0] hi, input int lat);
        txn_t t;
        t.name = name; t.rdata = rdata; t.lo_idx = lo_idx; t.lo = lo; t.hi = hi; t.lat = lat;
        q_txn.push_back(t);
    endtask

    task automatic push_snap(input string name, input logic rdy, input logic we_n, input logic oe_n,
                             input logic [15:0] dq, input logic [31:0] rdata,
                             input int mem_idx, input logic [15:0] mem_val);
        snap_t s;
        s.name = name; s.rdy = rdy; s.we_n = we_n; s.oe_n = oe_n; s.dq = dq;
        s.rdata = rdata; s.mem_idx = mem_idx; s.mem_val = mem_val;
        q_snap.push_back(s);
    endtask

    // Core model: hold the request until ready is seen high (the DONE cycle)
    task automatic do_txn(input string name, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d);
        bit ok;
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL %s timeout waiting for ready got 0 expected 1", name);
            $fatal(1, "ready never returned");
        end
    endtask

    // One idle cycle with a pin snapshot checked at its negedge
    task automatic snap_idle(input string name, input logic [31:0] rdata,
                             input int mem_idx, input logic [15:0] mem_val);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        push_snap(name, 1'b1, 1'b1, 1'b1, 16'hFFFF, rdata, mem_idx, mem_val);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        snap_t s;
        txn_t  t;
        int    low_cnt;
        low_cnt = 0;
        forever begin
            @(negedge clk);
            if (q_snap.size() > 0) begin
                s = q_snap.pop_front();
                chk({s.name, " ready"},     32'(ready),     32'(s.rdy));
                chk({s.name, " we_n"},      32'(sram_we_n), 32'(s.we_n));
                chk({s.name, " oe_n"},      32'(sram_oe_n), 32'(s.oe_n));
                chk({s.name, " dq"},        32'(sram_dq),   32'(s.dq));
                chk({s.name, " read_data"}, read_data,      s.rdata);
                if (s.mem_idx >= 0)
                    chk({s.name, " mem"}, 32'(mem[s.mem_idx]), 32'(s.mem_val));
            end
            if (ready !== 1'b1) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (q_txn.size() == 0) begin
                    chk("unexpected_txn", 32'(low_cnt), 32'd0);
                end else begin
                    t = q_txn.pop_front();
                    chk({t.name, " latency"},   32'(low_cnt),          32'(t.lat));
                    chk({t.name, " read_data"}, read_data,             t.rdata);
                    chk({t.name, " mem_lo"},    32'(mem[t.lo_idx]),    32'(t.lo));
                    chk({t.name, " mem_hi"},    32'(mem[t.lo_idx+1]),  32'(t.hi));
                end
                low_cnt = 0;
            end
            if (done) begin
                chk("pending_txn", 32'(q_txn.size()), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk); #1;
        push_snap("reset", 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h0, -1, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store then load
        push_txn("wr1024", 32'h0, 0, 16'hBEEF, 16'hDEAD, 7);
        do_txn("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        snap_idle("idle_a", 32'h0, 2, 16'h0000);
        push_txn("rd1024", 32'hDEADBEEF, 0, 16'hBEEF, 16'hDEAD, 7);
        do_txn("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0);

        // Address map
        push_txn("wr1032", 32'hDEADBEEF, 4, 16'h5678, 16'h1234, 7);
        do_txn("wr1032", 1'b1, 1'b0, 32'd1032, 32'h12345678);
        snap_idle("map_m6", 32'hDEADBEEF, 6, 16'h0000);
        snap_idle("map_m3", 32'hDEADBEEF, 3, 16'h0000);
        snap_idle("map_m0", 32'hDEADBEEF, 0, 16'hBEEF);

        // Simultaneous rd_en and wr_en: write wins
        push_txn("both1028", 32'hDEADBEEF, 2, 16'h5A5A, 16'hA5A5, 7);
        do_txn("both1028", 1'b1, 1'b1, 32'd1028, 32'hA5A55A5A);

        // Back-to-back loads
        push_txn("b2b_1024", 32'hDEADBEEF, 0, 16'hBEEF, 16'hDEAD, 7);
        push_txn("b2b_1032", 32'h12345678, 4, 16'h5678, 16'h1234, 7);
        do_txn("b2b_1024", 1'b0, 1'b1, 32'd1024, 32'h0);
        do_txn("b2b_1032", 1'b0, 1'b1, 32'd1032, 32'h0);
        snap_idle("after_b2b", 32'h12345678, -1, 16'h0);

        // Reset during the high-half write at 1040 (half-words 8/9)
        push_txn("rst_abort", 32'h0, 8, 16'hF00D, 16'h0000, 5);
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        push_snap("rst_in_high", 1'b0, 1'b1, 1'b1, 16'hFFFF, 32'h12345678, 9, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        push_snap("post_rst", 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h0, 9, 16'h0000);

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            snap_idle("idle", 32'h0, -1, 16'h0);
        end

        @(posedge clk); #1;
        done = 1'b1;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Responder side of the MEM-stage data-memory interface. The pipeline core is the initiator; this block answers its 32-bit load/store requests using an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two half-word SRAM accesses: low half first, then high half.
- `ready` is held low for the whole transaction so the core can freeze every pipeline stage.
- Sits between MEM_Stage and the board SRAM pins. It replaces the single-cycle data memory.

Parameters:
- ADDRESS_LEN, 32, byte address width from the core.
- REGISTER_LEN, 32, data word width.
- SRAM_ADDR_LEN, 18, SRAM half-word address width.
- SRAM_DATA_LEN, 16, SRAM data bus width.
- BASE_ADDR, 1024, first byte address of data memory; subtracted before mapping.
- PHASE_CYCLES, 3, clock cycles per half-word access; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  ADDRESS_LEN  byte address of the access.
- write_data  in  REGISTER_LEN  store data.
- read_data  out  REGISTER_LEN  load result; valid while ready=1 in DONE.
- ready  out  1  low means the transaction is in progress; the core freezes on !ready.
- SRAM_DQ  inout  SRAM_DATA_LEN  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_LEN  SRAM half-word address.
- SRAM_WE_N  out  1  SRAM write strobe, active low.
- SRAM_OE_N  out  1  SRAM output enable, active low.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE, counter = 0, read_data = 0.
  - SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_ADDR = 0, SRAM_DQ = high-Z.
- Reset in any state aborts the transaction. No partial write is completed after rst.
- Address map:
  - word_addr = (address − BASE_ADDR) >> 2.
  - Low half: SRAM_ADDR = {word_addr[SRAM_ADDR_LEN-2:0], 1'b0}.
  - High half: SRAM_ADDR = {word_addr[SRAM_ADDR_LEN-2:0], 1'b1}.
  - Upper address bits are ignored, so out-of-range addresses wrap.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE, when wr_en or rd_en is high:
    - Latch address, write_data and operation type (op = write if wr_en, else read).
    - Go to LOW with counter = 0.
    - If both wr_en and rd_en are high, the write wins and read_data is unchanged.
  - LOW:
    - Drive the low-half address.
    - Write: SRAM_DQ = data[15:0], SRAM_WE_N = 0, SRAM_OE_N = 1.
    - Read: SRAM_DQ = high-Z, SRAM_OE_N = 0, SRAM_WE_N = 1.
    - counter increments each cycle.
    - On the cycle with counter == PHASE_CYCLES−1: a read captures SRAM_DQ into read_data[15:0]; the next state is HIGH with counter = 0.
  - HIGH:
    - Same as LOW, using the high-half address and data[31:16] / read_data[31:16].
    - The next state is DONE.
  - DONE: SRAM_WE_N = 1, SRAM_OE_N = 1, bus high-Z. Unconditionally return to IDLE.
- ready is combinational:
  - ready = 1 when (state == IDLE and !wr_en and !rd_en), or when state == DONE.
  - It is 0 otherwise, including the IDLE cycle in which a request appears.
- Latency:
  - A request first seen at cycle t has ready low for cycles t .. t+2·PHASE_CYCLES.
  - ready is high at t+2·PHASE_CYCLES+1 (DONE), and the core advances on that edge.
- Back-to-back requests: the core still holds the old request during DONE. IDLE on the next cycle sees the next instruction's request, so no duplicate access occurs.
- read_data holds its last completed read value until the next read completes. Writes never modify read_data.
- Request inputs are sampled only in IDLE. Changes during LOW/HIGH are ignored because the latched values are used.
- WE_N is only low inside LOW/HIGH with a stable address; it is never low in IDLE or DONE.

Decomposition:
- Shared defines file holds:
  - the state encodings (2 bits);
  - SRAM_ADDR_LEN, SRAM_DATA_LEN and BASE_ADDR defaults;
  - the existing ADDRESS_LEN / REGISTER_LEN.
- No synthesizable sub-module is natural; the FSM, phase counter and tri-state driver fit in one module.
- Verification adds a behavioural sram_model: an asynchronous 16-bit array driving SRAM_DQ when OE_N=0 and WE_N=1.

Test Plan:
- Store then load (PHASE_CYCLES=3):
  - wr_en with address=1024, write_data=0xDEADBEEF. ready is low for 7 cycles and high on the 8th. Model holds [0]=0xBEEF, [1]=0xDEAD.
  - rd_en at 1024 → read_data=0xDEADBEEF when ready=1.
- Address map: store 0x12345678 at address=1032 → the model's half-words [4]=0x5678 and [5]=0x1234; no other location changes.
- Simultaneous rd_en and wr_en: address=1028, write_data=0xA5A5_5A5A, previous read_data=0xDEADBEEF → model is written, read_data stays 0xDEADBEEF.
- Back-to-back: load 1024 followed immediately by load 1032 → exactly two transactions, 16 cycles total with ready high once per transaction.
- Reset mid-write: assert rst during HIGH → next cycle state is IDLE, WE_N=1, DQ is high-Z, read_data=0, ready=1; the high half is not written.
- Idle: no request for 10 cycles → ready stays 1, WE_N=OE_N=1, SRAM_DQ is high-Z.
